// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Re-serializes parallel stereo sample pairs as Philips-format I2S in the
//   AMCLK_i domain. BCK and WS are derived from AMCLK_i. A one-pair holding
//   buffer decouples the sample strobe from the frame timing. Sticky flags
//   report overwritten (overrun) and missing (underrun) pairs.
//
// Ports
//   AMCLK_i         audio master clock, all logic on its rising edge
//   reset_n         asynchronous active-low reset
//   APDATA_LEFT_i   left sample (signed, MSB first on the wire)
//   APDATA_RIGHT_i  right sample
//   APDATA_VALID_i  one-cycle strobe, the pair is valid this cycle
//   mute_i          send zeros in place of samples at the next frame load
//   clr_flags_i     clears both sticky flags (a coincident set wins)
//   I2S_BCK_o       bit clock, AMCLK_i / BCK_DIV, 50% duty
//   I2S_WS_o        word select, 0 = left, 1 = right
//   I2S_DATA_o      serial data, changes on the BCK falling edge
//   overrun_o       sticky: an unconsumed held pair was overwritten
//   underrun_o      sticky: a frame started with no new pair held
//
// Handshake: APDATA_VALID_i has no ready; a pair is always captured into the
// hold buffer on the cycle its strobe is high.
module i2s_tx_serializer #(
  parameter int I2S_DATA_BITS = 16,
  parameter int SLOT_BITS     = 32,
  parameter int BCK_DIV       = 4
) (
  input  logic                     AMCLK_i,
  input  logic                     reset_n,
  input  logic [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
  input  logic                     APDATA_VALID_i,
  input  logic                     mute_i,
  input  logic                     clr_flags_i,
  output logic                     I2S_BCK_o,
  output logic                     I2S_WS_o,
  output logic                     I2S_DATA_o,
  output logic                     overrun_o,
  output logic                     underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCK_DIV);
  localparam int POS_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] WS_START = POS_W'(SLOT_BITS - 1);
  localparam logic [POS_W-1:0] WS_END   = POS_W'(FRAME_BITS - 2);

  logic [DIV_W-1:0]         div_ctr;
  logic [DIV_W-1:0]         div_nxt;
  logic [POS_W-1:0]         bit_pos;
  logic [POS_W-1:0]         pos_nxt;
  logic                     fall;
  logic                     load;
  logic [I2S_DATA_BITS-1:0] hold_l;
  logic [I2S_DATA_BITS-1:0] hold_r;
  logic                     hold_full;
  logic [I2S_DATA_BITS-1:0] act_l;
  logic [I2S_DATA_BITS-1:0] act_r;
  logic [I2S_DATA_BITS-1:0] new_l;
  logic [I2S_DATA_BITS-1:0] new_r;
  logic [FRAME_BITS-1:0]    frame_new;
  logic [FRAME_BITS-1:0]    frame_sr;
  logic                     ws_nxt;
  logic                     overrun_set;
  logic                     underrun_set;

  always_comb begin
    div_nxt = div_ctr + 1'b1;
    fall    = (div_ctr == DIV_LAST);
    load    = fall && (bit_pos == POS_LAST);
    pos_nxt = (bit_pos == POS_LAST) ? '0 : bit_pos + 1'b1;
    ws_nxt  = (pos_nxt >= WS_START) && (pos_nxt <= WS_END);

    // Words for the frame that starts at this load; on underrun the previous
    // pair is repeated.
    new_l = hold_full ? hold_l : act_l;
    new_r = hold_full ? hold_r : act_r;
    if (mute_i) begin
      new_l = '0;
      new_r = '0;
    end

    // Whole frame MSB-first: left word at the top of the left slot, right
    // word at the top of the right slot, zero padding elsewhere.
    frame_new = (FRAME_BITS'(new_l) << (FRAME_BITS - I2S_DATA_BITS))
              | (FRAME_BITS'(new_r) << (SLOT_BITS - I2S_DATA_BITS));

    overrun_set  = APDATA_VALID_i && hold_full && !load;
    underrun_set = load && !hold_full;
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      div_ctr    <= '0;
      bit_pos    <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_full  <= 1'b0;
      act_l      <= '0;
      act_r      <= '0;
      frame_sr   <= '0;
      I2S_BCK_o  <= 1'b0;
      I2S_WS_o   <= 1'b0;
      I2S_DATA_o <= 1'b0;
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      div_ctr   <= div_nxt;
      // Registered copy of the counter MSB as it will be after this edge, so
      // BCK falls on the same edge that WS and DATA change.
      I2S_BCK_o <= div_nxt[DIV_W-1];

      if (fall) begin
        bit_pos  <= pos_nxt;
        I2S_WS_o <= ws_nxt;
        if (load) begin
          act_l      <= new_l;
          act_r      <= new_r;
          I2S_DATA_o <= frame_new[FRAME_BITS-1];
          frame_sr   <= frame_new << 1;
        end else begin
          I2S_DATA_o <= frame_sr[FRAME_BITS-1];
          frame_sr   <= frame_sr << 1;
        end
      end

      // A strobe coinciding with a load refills the buffer the load empties.
      if (APDATA_VALID_i) begin
        hold_l    <= APDATA_LEFT_i;
        hold_r    <= APDATA_RIGHT_i;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (overrun_set)      overrun_o <= 1'b1;
      else if (clr_flags_i) overrun_o <= 1'b0;

      if (underrun_set)     underrun_o <= 1'b1;
      else if (clr_flags_i) underrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
//   Directed bench for i2s_tx_serializer with default parameters
//   (16-bit data, 32-bit slots, BCK_DIV = 4, 256-cycle frames).
//   A monitor records DATA and WS at every bit position, per frame, as
//   64-bit words with bit position 0 at the MSB; expected frames are built
//   from the driven sample pairs.
module tb_i2s_tx_serializer;

  localparam int NF = 12;
  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic        valid = 1'b0;
  logic        mute = 1'b0;
  logic        clr = 1'b0;
  logic        bck, ws, data, overrun, underrun;

  always #5 clk = ~clk;

  i2s_tx_serializer dut (
    .AMCLK_i        (clk),
    .reset_n        (reset_n),
    .APDATA_LEFT_i  (left),
    .APDATA_RIGHT_i (right),
    .APDATA_VALID_i (valid),
    .mute_i         (mute),
    .clr_flags_i    (clr),
    .I2S_BCK_o      (bck),
    .I2S_WS_o       (ws),
    .I2S_DATA_o     (data),
    .overrun_o      (overrun),
    .underrun_o     (underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Rising edges since reset release.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Frame capture, sampled on the falling edge.
  logic [63:0] fr_d [NF];
  logic [63:0] fr_w [NF];
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NF; i++) begin
        fr_d[i] <= '0;
        fr_w[i] <= '0;
      end
    end else if ((cyc % 4) == 0 && (cyc / 256) < NF) begin
      fr_d[cyc / 256][63 - ((cyc / 4) % 64)] <= data;
      fr_w[cyc / 256][63 - ((cyc / 4) % 64)] <= ws;
    end
  end

  // scoreboard
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    valid = 1'b0;
    mute = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the falling edge where cyc == c.
  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    check("sync", 64'(cyc), 64'(c));
  endtask

  // Pair is captured on rising edge number c.
  task automatic drive_pair(input int c, input logic [15:0] l, input logic [15:0] r);
    wait_until(c - 1);
    left = l;
    right = r;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- idle after reset: BCK/WS timing, zeros, underrun at first load
    do_reset();
    check("rst_bck", 64'(bck), 64'd0);
    check("rst_ws", 64'(ws), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    check("rst_und", 64'(underrun), 64'd0);
    for (int n = 1; n < 8; n++) begin
      wait_until(n);
      check("bck_pattern", 64'(bck), 64'((n % 4) >= 2));
    end
    wait_until(255);
    check("idle_und_pre", 64'(underrun), 64'd0);
    wait_until(256);
    check("idle_und_post", 64'(underrun), 64'd1);
    check("idle_ovr", 64'(overrun), 64'd0);
    wait_until(510);
    check("idle_f0_data", fr_d[0], 64'd0);
    check("idle_f0_ws", fr_w[0], WS_EXP);
    check("idle_f1_data", fr_d[1], 64'd0);
    check("idle_f1_ws", fr_w[1], WS_EXP);

    // ---- first pair, then one pair per frame for 8 frames
    do_reset();
    exp_q.delete();
    drive_pair(100, 16'hA5C3, 16'h8001);
    exp_q.push_back(frame_of(16'hA5C3, 16'h8001));
    for (int k = 0; k < 8; k++) begin
      drive_pair(256 * (k + 1) + 100, 16'h1000 + 16'(k * 16'h0111), 16'h8000 | 16'(k * 16'h0203));
      exp_q.push_back(frame_of(16'h1000 + 16'(k * 16'h0111), 16'h8000 | 16'(k * 16'h0203)));
    end
    wait_until(2558);
    for (int f = 1; f <= 9; f++) begin
      check($sformatf("stream_f%0d_data", f), fr_d[f], exp_q.pop_front());
      check($sformatf("stream_f%0d_ws", f), fr_w[f], WS_EXP);
    end
    check("stream_ovr", 64'(overrun), 64'd0);
    check("stream_und", 64'(underrun), 64'd0);

    // ---- overrun, flag clear, valid on the load edge, underrun repeat
    do_reset();
    drive_pair(50, 16'h1111, 16'h2222);
    drive_pair(60, 16'h3333, 16'h4444);
    wait_until(61);
    check("ovr_set", 64'(overrun), 64'd1);
    drive_pair(400, 16'h5555, 16'h6666);
    wait_until(510);
    check("ovr_second_sent", fr_d[1], frame_of(16'h3333, 16'h4444));
    clr = 1'b1;
    wait_until(511);
    clr = 1'b0;
    check("clr_ovr", 64'(overrun), 64'd0);
    check("clr_und", 64'(underrun), 64'd0);
    drive_pair(512, 16'h7E81, 16'hFFFF);
    check("load_valid_ovr", 64'(overrun), 64'd0);
    check("load_valid_und", 64'(underrun), 64'd0);
    wait_until(1023);
    check("skip_und_pre", 64'(underrun), 64'd0);
    wait_until(1024);
    check("skip_und_post", 64'(underrun), 64'd1);
    wait_until(1278);
    check("load_old_sent", fr_d[2], frame_of(16'h5555, 16'h6666));
    check("load_new_sent", fr_d[3], frame_of(16'h7E81, 16'hFFFF));
    check("skip_repeat", fr_d[4], frame_of(16'h7E81, 16'hFFFF));
    check("skip_ovr", 64'(overrun), 64'd0);

    // ---- mute consumes the hold buffer
    do_reset();
    mute = 1'b1;
    drive_pair(100, 16'hFFFF, 16'hFFFF);
    wait_until(300);
    mute = 1'b0;
    wait_until(510);
    check("mute_f1_data", fr_d[1], 64'd0);
    check("mute_f1_ws", fr_w[1], WS_EXP);
    wait_until(512);
    check("mute_consumed_und", 64'(underrun), 64'd1);
    check("mute_ovr", 64'(overrun), 64'd0);
    wait_until(766);
    check("mute_f2_data", fr_d[2], 64'd0);

    // ---- reset in the middle of a frame (p = 20, BCK high)
    do_reset();
    drive_pair(50, 16'hC001, 16'h0FF0);
    drive_pair(60, 16'hBEEF, 16'h1234);
    wait_until(338);
    check("mid_pre_bck", 64'(bck), 64'd1);
    check("mid_pre_ovr", 64'(overrun), 64'd1);
    check("mid_f1_partial", fr_d[1][63:48], 64'h0000_0000_0000_BEEF);
    #1 reset_n = 1'b0;
    #1;
    check("mid_async_bck", 64'(bck), 64'd0);
    check("mid_async_ovr", 64'(overrun), 64'd0);
    check("mid_async_data", 64'(data), 64'd0);
    check("mid_async_ws", 64'(ws), 64'd0);
    do_reset();
    wait_until(255);
    check("mid_restart_und_pre", 64'(underrun), 64'd0);
    wait_until(256);
    check("mid_restart_und_post", 64'(underrun), 64'd1);
    wait_until(510);
    check("mid_restart_f0_ws", fr_w[0], WS_EXP);
    check("mid_restart_f0_data", fr_d[0], 64'd0);
    check("mid_restart_f1_data", fr_d[1], 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
